// File: rtl/pixel_dispatcher.sv
// Raster-order pixel coordinate dispatcher feeding up to two compute cores
// in strict round-robin with one outstanding coordinate at a time.
module pixel_dispatcher #(
  parameter int MAX_CORES = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  input  logic [2:0]  no_of_extra_cores,
  output logic [12:0] x1,
  output logic [12:0] y1,
  output logic        valid1,
  output logic        sof1,
  output logic        eol1,
  input  logic        core_ready_1,
  output logic [12:0] x2,
  output logic [12:0] y2,
  output logic        valid2,
  output logic        sof2,
  output logic        eol2,
  input  logic        core_ready_2,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [12:0] w_q, w_d, h_q, h_d;
  logic [12:0] x_q, x_d, y_q, y_d;
  logic        two_q, two_d;
  logic        cur_q, cur_d;
  logic [12:0] x1_q, x1_d, y1_q, y1_d;
  logic [12:0] x2_q, x2_d, y2_q, y2_d;
  logic        v1_q, v1_d, s1_q, s1_d, e1_q, e1_d;
  logic        v2_q, v2_d, s2_q, s2_d, e2_q, e2_d;
  logic        busy_q, busy_d;
  logic        fd_q, fd_d;

  logic        hs, last_x, last_y;
  logic        pres;
  logic        pres_c;
  logic [12:0] pres_x, pres_y, pres_w;
  logic        pres_sof, pres_eol;

  assign hs     = (v1_q & core_ready_1) | (v2_q & core_ready_2);
  assign last_x = (x_q == w_q - 13'd1);
  assign last_y = (y_q == h_q - 13'd1);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    two_d   = two_q;
    x_d     = x_q;
    y_d     = y_q;
    cur_d   = cur_q;
    fd_d    = 1'b0;
    pres    = 1'b0;
    pres_c  = cur_q;
    pres_x  = x_q;
    pres_y  = y_q;
    pres_w  = w_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && image_width != 13'd0 && image_height != 13'd0) begin
          w_d     = image_width;
          h_d     = image_height;
          two_d   = (no_of_extra_cores != 3'd0) && (MAX_CORES >= 2);
          x_d     = 13'd0;
          y_d     = 13'd0;
          cur_d   = 1'b0;
          state_d = S_RUN;
          pres    = 1'b1;
          pres_c  = 1'b0;
          pres_x  = 13'd0;
          pres_y  = 13'd0;
          pres_w  = image_width;
        end
      end
      S_RUN: begin
        if (hs) begin
          v1_d = 1'b0;
          v2_d = 1'b0;
          if (last_x && last_y) begin
            state_d = S_DONE;
            fd_d    = 1'b1;
          end else begin
            x_d   = last_x ? 13'd0 : x_q + 13'd1;
            y_d   = last_x ? y_q + 13'd1 : y_q;
            cur_d = two_q ? ~cur_q : 1'b0;
          end
        end else if (!v1_q && !v2_q) begin
          pres = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers only load when a new coordinate is presented.
  always_comb begin
    pres_sof = (pres_x == 13'd0) && (pres_y == 13'd0);
    pres_eol = (pres_x == pres_w - 13'd1);
    x1_d = x1_q;
    y1_d = y1_q;
    s1_d = s1_q;
    e1_d = e1_q;
    x2_d = x2_q;
    y2_d = y2_q;
    s2_d = s2_q;
    e2_d = e2_q;
    if (pres && !pres_c) begin
      x1_d = pres_x;
      y1_d = pres_y;
      s1_d = pres_sof;
      e1_d = pres_eol;
    end
    if (pres && pres_c) begin
      x2_d = pres_x;
      y2_d = pres_y;
      s2_d = pres_sof;
      e2_d = pres_eol;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      w_q     <= 13'd0;
      h_q     <= 13'd0;
      two_q   <= 1'b0;
      x_q     <= 13'd0;
      y_q     <= 13'd0;
      cur_q   <= 1'b0;
      x1_q    <= 13'd0;
      y1_q    <= 13'd0;
      x2_q    <= 13'd0;
      y2_q    <= 13'd0;
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      e1_q    <= 1'b0;
      v2_q    <= 1'b0;
      s2_q    <= 1'b0;
      e2_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      two_q   <= two_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cur_q   <= cur_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      v1_q    <= (pres && !pres_c) ? 1'b1 : v1_d;
      s1_q    <= s1_d;
      e1_q    <= e1_d;
      v2_q    <= (pres && pres_c) ? 1'b1 : v2_d;
      s2_q    <= s2_d;
      e2_q    <= e2_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign x1         = x1_q;
  assign y1         = y1_q;
  assign valid1     = v1_q;
  assign sof1       = s1_q;
  assign eol1       = e1_q;
  assign x2         = x2_q;
  assign y2         = y2_q;
  assign valid2     = v2_q;
  assign sof2       = s2_q;
  assign eol2       = e2_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher: a raster/round-robin model fills
// an expected queue; a negedge monitor pops and compares on each handshake.
module tb_pixel_dispatcher;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] image_width = '0;
  logic [12:0] image_height = '0;
  logic [2:0]  no_of_extra_cores = '0;
  logic [12:0] x1, y1, x2, y2;
  logic        valid1, sof1, eol1, valid2, sof2, eol2;
  logic        core_ready_1 = 1'b0;
  logic        core_ready_2 = 1'b0;
  logic        busy, frame_done;

  always #5 aclk = ~aclk;

  pixel_dispatcher #(.MAX_CORES(2)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .image_width(image_width), .image_height(image_height),
    .no_of_extra_cores(no_of_extra_cores),
    .x1(x1), .y1(y1), .valid1(valid1), .sof1(sof1), .eol1(eol1),
    .core_ready_1(core_ready_1),
    .x2(x2), .y2(y2), .valid2(valid2), .sof2(sof2), .eol2(eol2),
    .core_ready_2(core_ready_2),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct packed {
    logic        c;
    logic [12:0] x;
    logic [12:0] y;
    logic        s;
    logic        e;
  } pix_t;

  pix_t exp_q[$];
  int   pend_done = 0;
  int   hs_cnt = 0;
  int   total = 0;
  int   bad = 0;
  int   rmode = 0;
  int   stall_cnt = 0;
  int   tog = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: pixel i of the frame goes to core (i mod ncores).
  function automatic void model(input int w, input int h, input int extra);
    int n;
    pix_t p;
    n = (extra >= 1) ? 2 : 1;
    for (int i = 0; i < w * h; i++) begin
      p.x = 13'(i % w);
      p.y = 13'(i / w);
      p.c = (n == 2) ? 1'(i % 2) : 1'b0;
      p.s = (i == 0);
      p.e = ((i % w) == w - 1);
      exp_q.push_back(p);
    end
    pend_done++;
  endfunction

  task automatic take(input logic c, input logic [12:0] x,
                      input logic [12:0] y, input logic s, input logic e);
    pix_t p;
    hs_cnt++;
    if (exp_q.size() == 0) begin
      check("unexpected_pixel", {c, x, y, s, e}, 32'hffff_ffff);
    end else begin
      p = exp_q.pop_front();
      check("pixel", {c, x, y, s, e}, p);
    end
  endtask

  logic        st1 = 1'b0, st2 = 1'b0;
  logic [27:0] sv1 = '0, sv2 = '0;

  always @(negedge aclk) begin
    if (areset) begin
      st1 <= 1'b0;
      st2 <= 1'b0;
    end else begin
      if (valid1 || valid2) check("one_valid", {31'b0, valid1 & valid2}, 0);
      if (st1) check("hold1", {4'b0, valid1, x1, y1, sof1}, {4'b0, sv1});
      if (st2) check("hold2", {4'b0, valid2, x2, y2, sof2}, {4'b0, sv2});
      st1 <= valid1 && !core_ready_1;
      st2 <= valid2 && !core_ready_2;
      sv1 <= {valid1, x1, y1, sof1};
      sv2 <= {valid2, x2, y2, sof2};
      if (valid1 && core_ready_1) take(1'b0, x1, y1, sof1, eol1);
      if (valid2 && core_ready_2) take(1'b1, x2, y2, sof2, eol2);
      if (frame_done) begin
        check("frame_done", {30'b0, exp_q.size() == 0, pend_done > 0}, 3);
        if (pend_done > 0) pend_done--;
      end
    end
  end

  always @(posedge aclk) begin
    #1;
    case (rmode)
      0: begin core_ready_1 = 1'b1; core_ready_2 = 1'b1; end
      1: begin
        core_ready_1 = 1'($urandom);
        core_ready_2 = 1'($urandom);
      end
      2: begin
        tog++;
        if (tog >= 3) begin
          core_ready_1 = ~core_ready_1;
          tog = 0;
        end
        core_ready_2 = 1'($urandom);
      end
      default: begin
        core_ready_1 = 1'b1;
        core_ready_2 = (stall_cnt > 0) ? 1'b0 : 1'b1;
        if (stall_cnt > 0) stall_cnt--;
      end
    endcase
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    exp_q.delete();
    pend_done = 0;
  endtask

  task automatic start_frame(input int w, input int h, input int extra);
    image_width = 13'(w);
    image_height = 13'(h);
    no_of_extra_cores = 3'(extra);
    start = 1'b1;
    model(w, h, extra);
    tick();
    start = 1'b0;
    @(negedge aclk);
    check("first_valid", {4'b0, valid1, x1, y1, sof1, busy},
          {4'b0, 1'b1, 26'b0, 1'b1, 1'b1});
  endtask

  task automatic wait_frame(input int budget, input bit perturb);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
      if (perturb && n == 3) begin
        image_width = 13'($urandom_range(1, 9));
        image_height = 13'($urandom_range(1, 9));
        no_of_extra_cores = 3'($urandom);
        if (busy) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    check("frame_timeout", {31'b0, busy}, 0);
    if (busy) do_reset();
    tick();
    tick();
    check("drain", exp_q.size() + pend_done, 0);
  endtask

  initial begin
    tick();
    tick();
    @(negedge aclk);
    check("reset_state",
          {valid1, valid2, busy, frame_done, sof1, eol1, sof2, eol2,
           x1 | x2 | y1 | y2}, 0);
    areset = 1'b0;
    tick();

    rmode = 0;
    start_frame(4, 2, 1);
    wait_frame(200, 0);

    rmode = 2;
    start_frame(4, 2, 0);
    wait_frame(400, 0);

    rmode = 0;
    start_frame(1, 1, 3);
    wait_frame(50, 0);
    check("busy_after_1x1", {31'b0, busy}, 0);

    rmode = 3;
    stall_cnt = 20;
    start_frame(4, 1, 1);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("stall_core2", {4'b0, valid1, valid2, x2, y2}, {4'b0, 2'b01, 13'd1, 13'd0});
      tick();
    end
    wait_frame(200, 0);

    rmode = 0;
    image_width = 13'd4;
    image_height = 13'd2;
    no_of_extra_cores = 3'd1;
    start = 1'b1;
    model(4, 2, 1);
    tick();
    start = 1'b0;
    for (int n = 0; n < 50 && hs_cnt < 3; n++) tick();
    hs_cnt = 0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    exp_q.delete();
    pend_done = 0;
    @(negedge aclk);
    check("mid_reset", {28'b0, valid1, valid2, busy, frame_done}, 0);
    tick();
    start_frame(4, 2, 1);
    wait_frame(200, 0);

    start = 1'b1;
    image_width = 13'd0;
    image_height = 13'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        image_width = 13'd3;
        image_height = 13'd0;
      end
      tick();
      @(negedge aclk);
      check("zero_size", {29'b0, busy, valid1, valid2}, 0);
    end
    start = 1'b0;
    tick();

    for (int f = 0; f < 8; f++) begin
      rmode = 1;
      start_frame($urandom_range(1, 6), $urandom_range(1, 4),
                  $urandom_range(0, 7));
      wait_frame(1000, 1);
    end

    rmode = 0;
    start_frame(8191, 1, 1);
    wait_frame(40000, 0);
    start_frame(1, 8191, 2);
    wait_frame(40000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
